// File: rtl/front_seq_pkg.sv
// Shared types and phase constants for the front (sprite) layer fetch sequencer.
package front_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam int unsigned PH_W   = 3;
    localparam int unsigned SLOT_W = 6;

    localparam logic [PH_W-1:0] PH_VLK  = 3'd2;
    localparam logic [PH_W-1:0] PH_FCK  = 3'd3;
    localparam logic [PH_W-1:0] PH_LC   = 3'd4;
    localparam logic [PH_W-1:0] PH_CPU0 = 3'd5;
    localparam logic [PH_W-1:0] PH_CPU1 = 3'd6;
    localparam logic [PH_W-1:0] PH_LD   = 3'd7;

endpackage

// File: rtl/front_seq_phase_ctr.sv
// Phase (pixel within slot) and slot counters with pix_cen enable, sync clear and
// terminal count at the last phase of the last slot.
module front_seq_phase_ctr
    import front_seq_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 64,
    parameter int unsigned PHASES    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [PH_W-1:0]   ph_next_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              tc_o
);

    localparam logic [PH_W-1:0]   PhLast   = PH_W'(PHASES - 1);
    localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(NUM_SLOTS - 1);

    logic [PH_W-1:0]   ph_q, ph_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        ph_d   = ph_q;
        slot_d = slot_q;
        if (clr_i) begin
            ph_d   = '0;
            slot_d = '0;
        end else if (en_i) begin
            if (ph_q == PhLast) begin
                ph_d   = '0;
                slot_d = slot_q + 1'b1;
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q   <= '0;
            slot_q <= '0;
        end else begin
            ph_q   <= ph_d;
            slot_q <= slot_d;
        end
    end

    assign ph_next_o = ph_d;
    assign slot_o    = slot_q;
    assign tc_o      = (ph_q == PhLast) && (slot_q == SlotLast);

endmodule

// File: rtl/front_sprite_fetch_sequencer.sv
// Per-scanline sprite attribute fetch sequencer with front SRAM address arbitration.
// Define FRONT_SEQ_CPU_SLOT_EN to grant CPU accesses in phases 5-6 of each fetch slot.
module front_sprite_fetch_sequencer
    import front_seq_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 64,
    parameter int unsigned PHASES    = 8
) (
    input  logic       clk,
    input  logic       VIDEO_RST,
    input  logic       pix_cen,
    input  logic       line_start,
    input  logic       cpu_req,
    output logic       cpu_ack,
    output logic       V_C,
    output logic [4:0] FH,
    output logic       H3,
    output logic       VCKn,
    output logic       VLK,
    output logic       FCK,
    output logic       LC,
    output logic       LD,
    output logic       busy,
    output logic       done
);

    seq_state_e        state_q, state_d;
    logic              served_q, served_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              v_c_q, v_c_d;
    logic              vckn_q, vckn_d;
    logic              vlk_q, vlk_d;
    logic              fck_q, fck_d;
    logic              lc_q, lc_d;
    logic              ld_q, ld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              win_d;

    logic              en, enter, tc, grant;
    logic [PH_W-1:0]   ph_next;
    logic [SLOT_W-1:0] slot;

    assign en    = (state_q == FETCH) && pix_cen;
    assign enter = en && !line_start;

    front_seq_phase_ctr #(
        .NUM_SLOTS (NUM_SLOTS),
        .PHASES    (PHASES)
    ) u_ctr (
        .clk_i     (clk),
        .rst_i     (VIDEO_RST),
        .en_i      (en),
        .clr_i     (line_start || (en && tc)),
        .ph_next_o (ph_next),
        .slot_o    (slot),
        .tc_o      (tc)
    );

`ifdef FRONT_SEQ_CPU_SLOT_EN
    logic win_q;
    logic grant_slot;

    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            win_q <= 1'b0;
        end else begin
            win_q <= win_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (line_start) state_d = FETCH;
            FETCH:   if (!line_start && en && tc) state_d = DONE;
            DONE:    state_d = line_start ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        // line_start beats a simultaneous CPU request; the CPU waits for the next window
        grant = (state_q == IDLE) && !line_start && cpu_req && !served_q;
        win_d = 1'b0;
`ifdef FRONT_SEQ_CPU_SLOT_EN
        grant_slot = enter && (ph_next == PH_CPU0) && cpu_req && !served_q;
        grant      = grant || grant_slot;
        win_d      = (state_d == FETCH) && ((ph_next == PH_CPU0) || (ph_next == PH_CPU1)) &&
                     (grant_slot || win_q);
`endif
        // Served flag blocks a second ack while the requester is still dropping cpu_req
        served_d  = cpu_req && (served_q || grant);
        cpu_ack_d = grant;

        v_c_d  = (state_d == IDLE) || win_d;
        vckn_d = !((state_d == FETCH) && (ph_next < PH_VLK));
        vlk_d  = enter && (ph_next == PH_VLK);
        fck_d  = enter && (ph_next == PH_FCK);
        lc_d   = enter && (ph_next == PH_LC);
        ld_d   = !((state_d == FETCH) && (ph_next == PH_LD));
        busy_d = (state_d == FETCH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            state_q   <= IDLE;
            served_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            v_c_q     <= 1'b1;
            vckn_q    <= 1'b1;
            vlk_q     <= 1'b0;
            fck_q     <= 1'b0;
            lc_q      <= 1'b0;
            ld_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            served_q  <= served_d;
            cpu_ack_q <= cpu_ack_d;
            v_c_q     <= v_c_d;
            vckn_q    <= vckn_d;
            vlk_q     <= vlk_d;
            fck_q     <= fck_d;
            lc_q      <= lc_d;
            ld_q      <= ld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cpu_ack = cpu_ack_q;
    assign V_C     = v_c_q;
    assign FH      = slot[5:1];
    assign H3      = slot[0];
    assign VCKn    = vckn_q;
    assign VLK     = vlk_q;
    assign FCK     = fck_q;
    assign LC      = lc_q;
    assign LD      = ld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_front_sprite_fetch_sequencer.sv
// Directed, table-driven bench for front_sprite_fetch_sequencer with a 4-slot line.
module tb_front_sprite_fetch_sequencer;

    localparam int unsigned NSLOT = 4;
    localparam int          LINE_TICKS = NSLOT * 8;

    logic       clk = 1'b0;
    logic       VIDEO_RST, pix_cen, line_start, cpu_req;
    logic       cpu_ack, V_C, H3, VCKn, VLK, FCK, LC, LD, busy, done;
    logic [4:0] FH;

    int checks = 0;
    int errors = 0;

    int   ticks, n_vlk, n_fck, n_lc, n_ld, n_done, n_ack, ack_tick, done_tick;
    int   n_vc_hi, n_vc_bad, n_slot_bad;
    logic ld_prev;
    logic req_r;

    always #5 clk = ~clk;

    front_sprite_fetch_sequencer #(
        .NUM_SLOTS (NSLOT),
        .PHASES    (8)
    ) dut (
        .clk        (clk),
        .VIDEO_RST  (VIDEO_RST),
        .pix_cen    (pix_cen),
        .line_start (line_start),
        .cpu_req    (cpu_req),
        .cpu_ack    (cpu_ack),
        .V_C        (V_C),
        .FH         (FH),
        .H3         (H3),
        .VCKn       (VCKn),
        .VLK        (VLK),
        .FCK        (FCK),
        .LC         (LC),
        .LD         (LD),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic       ls, pc, req;
        logic [5:0] slot;
        logic       vckn, vc, vlk, fck, lc, ld, bsy, dn, ack;
    } vec_t;

    vec_t vt[16];

    function automatic logic [31:0] slot_now();
        return 32'({FH, H3});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".slot"}, slot_now(), 0);
        check({tag, ".VCKn"}, 32'(VCKn), 1);
        check({tag, ".V_C"}, 32'(V_C), 1);
        check({tag, ".VLK"}, 32'(VLK), 0);
        check({tag, ".FCK"}, 32'(FCK), 0);
        check({tag, ".LC"}, 32'(LC), 0);
        check({tag, ".LD"}, 32'(LD), 1);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".ack"}, 32'(cpu_ack), 0);
    endtask

    task automatic tick(input logic ls, input logic pc, input logic req);
        line_start = ls;
        pix_cen    = pc;
        cpu_req    = req;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_vlk = 0; n_fck = 0; n_lc = 0; n_ld = 0; n_done = 0; n_ack = 0;
        ack_tick = -1; done_tick = -1; n_vc_hi = 0; n_vc_bad = 0; n_slot_bad = 0;
        ld_prev = 1'b1;
    endtask

    task automatic sample();
        if (VLK) begin
            if (slot_now() != 32'(n_vlk)) n_slot_bad++;
            n_vlk++;
        end
        if (FCK) n_fck++;
        if (LC) n_lc++;
        if (!LD && ld_prev) n_ld++;
        ld_prev = LD;
        if (done) begin
            n_done++;
            done_tick = ticks;
        end
        if (cpu_ack) begin
            n_ack++;
            ack_tick = ticks;
        end
        if (busy && V_C) begin
            n_vc_hi++;
            if ((ticks % 8) != 5 && (ticks % 8) != 6) n_vc_bad++;
        end
    endtask

    // One gap clk then one pix_cen clk; the second sample lands right after the tick
    task automatic adv(input logic req);
        tick(1'b0, 1'b0, req);
        sample();
        tick(1'b0, 1'b1, req);
        ticks++;
        sample();
    endtask

    task automatic start_line(input logic req);
        clear_stats();
        tick(1'b1, 1'b0, req);
        ticks = 0;
        sample();
    endtask

    task automatic run_to_done();
        for (int i = 0; i < LINE_TICKS + 8 && n_done == 0; i++) begin
            adv(req_r);
            if (n_ack != 0) req_r = 1'b0;
        end
    endtask

    initial begin
        //         ls pc rq slot vckn vc vlk fck lc ld bsy dn ack
        vt[0]  = '{0, 0, 0, 6'd0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 6'd0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
        vt[2]  = '{0, 0, 1, 6'd0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 6'd0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        vt[4]  = '{1, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[5]  = '{0, 1, 0, 6'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[6]  = '{0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[7]  = '{0, 1, 0, 6'd0, 1, 0, 1, 0, 0, 1, 1, 0, 0};
        vt[8]  = '{0, 0, 0, 6'd0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[9]  = '{0, 1, 0, 6'd0, 1, 0, 0, 1, 0, 1, 1, 0, 0};
        vt[10] = '{0, 1, 0, 6'd0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
        vt[11] = '{0, 1, 0, 6'd0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[12] = '{0, 1, 0, 6'd0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[13] = '{0, 1, 0, 6'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[14] = '{0, 0, 0, 6'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[15] = '{0, 1, 0, 6'd1, 0, 0, 0, 0, 0, 1, 1, 0, 0};

        VIDEO_RST = 1'b1; pix_cen = 1'b0; line_start = 1'b0; cpu_req = 1'b0; req_r = 1'b0;
        ticks = 0;
        clear_stats();
        #2;
        check_reset("por");
        @(posedge clk);
        #1;
        VIDEO_RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tick(vt[i].ls, vt[i].pc, vt[i].req);
            check($sformatf("v%0d.slot", i), slot_now(), 32'(vt[i].slot));
            check($sformatf("v%0d.VCKn", i), 32'(VCKn), 32'(vt[i].vckn));
            check($sformatf("v%0d.V_C", i), 32'(V_C), 32'(vt[i].vc));
            check($sformatf("v%0d.VLK", i), 32'(VLK), 32'(vt[i].vlk));
            check($sformatf("v%0d.FCK", i), 32'(FCK), 32'(vt[i].fck));
            check($sformatf("v%0d.LC", i), 32'(LC), 32'(vt[i].lc));
            check($sformatf("v%0d.LD", i), 32'(LD), 32'(vt[i].ld));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].bsy));
            check($sformatf("v%0d.done", i), 32'(done), 32'(vt[i].dn));
            check($sformatf("v%0d.ack", i), 32'(cpu_ack), 32'(vt[i].ack));
        end

        // Full line from a restart
        req_r = 1'b0;
        start_line(1'b0);
        run_to_done();
        check("line.vlk", 32'(n_vlk), NSLOT);
        check("line.fck", 32'(n_fck), NSLOT);
        check("line.lc", 32'(n_lc), NSLOT);
        check("line.ld_low", 32'(n_ld), NSLOT);
        check("line.slot_order", 32'(n_slot_bad), 0);
        check("line.done_cnt", 32'(n_done), 1);
        check("line.done_tick", 32'(done_tick), LINE_TICKS);
        check("line.vc_hi", 32'(n_vc_hi), 0);
        tick(1'b0, 1'b0, 1'b0);
        check("post.done", 32'(done), 0);
        check("post.busy", 32'(busy), 0);
        check("post.V_C", 32'(V_C), 1);

        // Abort at slot 2 phase 4, then a complete line
        start_line(1'b0);
        for (int i = 0; i < 20; i++) adv(1'b0);
        check("abort.slot", slot_now(), 2);
        check("abort.LC", 32'(LC), 1);
        check("abort.no_done", 32'(n_done), 0);
        start_line(1'b0);
        check("restart.slot", slot_now(), 0);
        check("restart.VCKn", 32'(VCKn), 0);
        check("restart.busy", 32'(busy), 1);
        check("restart.done", 32'(done), 0);
        run_to_done();
        check("restart.done_cnt", 32'(n_done), 1);
        check("restart.done_tick", 32'(done_tick), LINE_TICKS);
        check("restart.vlk", 32'(n_vlk), NSLOT);

        // CPU request raised at slot 1 phase 1
        req_r = 1'b0;
        start_line(1'b0);
        for (int i = 0; i < 9; i++) adv(1'b0);
        req_r = 1'b1;
        run_to_done();
        check("cpu.done_tick", 32'(done_tick), LINE_TICKS);
`ifdef FRONT_SEQ_CPU_SLOT_EN
        check("cpu.ack_cnt", 32'(n_ack), 1);
        check("cpu.ack_tick", 32'(ack_tick), 13);
        check("cpu.vc_hi", 32'(n_vc_hi), 4);
        check("cpu.vc_bad", 32'(n_vc_bad), 0);
        tick(1'b0, 1'b0, 1'b0);
        check("cpu.idle_ack", 32'(cpu_ack), 0);
`else
        check("cpu.ack_in_line", 32'(n_ack), 0);
        check("cpu.vc_hi", 32'(n_vc_hi), 0);
        tick(1'b0, 1'b0, 1'b1);
        check("cpu.ack_d1", 32'(cpu_ack), 0);
        check("cpu.vc_d1", 32'(V_C), 1);
        tick(1'b0, 1'b0, 1'b1);
        check("cpu.ack_d2", 32'(cpu_ack), 1);
        check("cpu.vc_d2", 32'(V_C), 1);
        tick(1'b0, 1'b0, 1'b0);
        check("cpu.ack_d3", 32'(cpu_ack), 0);
`endif
        tick(1'b0, 1'b0, 1'b0);

        // Asynchronous reset at slot 3 phase 7 with a CPU request pending
        req_r = 1'b0;
        start_line(1'b0);
        for (int i = 0; i < 31; i++) adv(1'b0);
        check("rst.pre_slot", slot_now(), 3);
        check("rst.pre_LD", 32'(LD), 0);
        cpu_req = 1'b1;
        #2;
        VIDEO_RST = 1'b1;
        #1;
        check_reset("rst_mid");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            check($sformatf("rst_hold%0d.ack", i), 32'(cpu_ack), 0);
            check($sformatf("rst_hold%0d.busy", i), 32'(busy), 0);
        end
        VIDEO_RST = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        check("rst.ack_after", 32'(cpu_ack), 1);
        tick(1'b0, 1'b0, 1'b0);
        check("rst.ack_single", 32'(cpu_ack), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
